// File: rtl/gpio_cond_pkg.sv
// Shared types and defaults for the GPIO input conditioning path.
// Edge mode encoding matches the two-bit per-pin configuration field.
package gpio_cond_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_WIDTH_DEF   = 16;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

endpackage

// File: rtl/gpio_in_conditioner_if.sv
// Pad, configuration and status bundle of the GPIO input conditioner.
// master drives pads/config, slave is the conditioner itself.
interface gpio_in_conditioner_if #(
  parameter int NB_GPIO   = 32,
  parameter int CNT_WIDTH = 16
);

  logic [NB_GPIO-1:0]   gpio_pad_i;
  logic [CNT_WIDTH-1:0] presc_i;
  logic [CNT_WIDTH-1:0] dbnc_len_i;
  logic [NB_GPIO-1:0]   dbnc_en_i;
  logic [2*NB_GPIO-1:0] edge_mode_i;
  logic [NB_GPIO-1:0]   irq_en_i;
  logic [NB_GPIO-1:0]   status_clr_i;
  logic [NB_GPIO-1:0]   gpio_in_o;
  logic [NB_GPIO-1:0]   rise_o;
  logic [NB_GPIO-1:0]   fall_o;
  logic [NB_GPIO-1:0]   status_o;
  logic                 irq_o;

  modport master (
    output gpio_pad_i, presc_i, dbnc_len_i, dbnc_en_i,
    output edge_mode_i, irq_en_i, status_clr_i,
    input  gpio_in_o, rise_o, fall_o, status_o, irq_o
  );

  modport slave (
    input  gpio_pad_i, presc_i, dbnc_len_i, dbnc_en_i,
    input  edge_mode_i, irq_en_i, status_clr_i,
    output gpio_in_o, rise_o, fall_o, status_o, irq_o
  );

endinterface

// File: rtl/gpio_dbnc_cell.sv
// One GPIO pin: synchronizer, tick-based debounce, edge pulses and
// sticky edge status.
module gpio_dbnc_cell
  import gpio_cond_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_pad,
  input  logic                 i_tick,
  input  logic [CNT_WIDTH-1:0] i_len,
  input  logic                 i_dbnc_en,
  input  edge_mode_e           i_mode,
  input  logic                 i_clr,
  output logic                 o_stable,
  output logic                 o_rise,
  output logic                 o_fall,
  output logic                 o_status
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_WIDTH-1:0]   r_dcnt;
  logic [CNT_WIDTH-1:0]   w_dcnt_nxt;
  logic                   r_stable;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_status;
  logic                   w_stable_nxt;
  logic                   w_sync;
  logic                   w_byp;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_set;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_byp  = !i_dbnc_en || (i_len == '0);

  // A mismatch that survives i_len ticks is accepted; any
  // return to the stable level restarts the count.
  always_comb begin
    w_stable_nxt = r_stable;
    w_dcnt_nxt   = r_dcnt;
    if (w_byp) begin
      w_stable_nxt = w_sync;
      w_dcnt_nxt   = '0;
    end else if (w_sync == r_stable) begin
      w_dcnt_nxt = '0;
    end else if (i_tick) begin
      if (CNT_WIDTH'(r_dcnt + 1'b1) == i_len) begin
        w_stable_nxt = w_sync;
        w_dcnt_nxt   = '0;
      end else begin
        w_dcnt_nxt = CNT_WIDTH'(r_dcnt + 1'b1);
      end
    end
  end

  assign w_rise = w_stable_nxt & ~r_stable;
  assign w_fall = ~w_stable_nxt & r_stable;

  always_comb begin
    w_set = 1'b0;
    unique case (i_mode)
      EDGE_RISE: w_set = w_rise;
      EDGE_FALL: w_set = w_fall;
      EDGE_BOTH: w_set = w_rise | w_fall;
      default:   w_set = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync   <= '0;
      r_dcnt   <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_status <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_pad};
      r_dcnt   <= w_dcnt_nxt;
      r_stable <= w_stable_nxt;
      r_rise   <= w_rise;
      r_fall   <= w_fall;
      r_status <= w_set | (r_status & ~i_clr);
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;
  assign o_status = r_status;

endmodule

// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: shared debounce prescaler, one cell per
// pin, and the interrupt reduction over enabled status bits.
module gpio_in_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int NB_GPIO     = 32,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input logic                 clk,
  input logic                 rst,
  gpio_in_conditioner_if.slave bus
);

  logic [CNT_WIDTH-1:0] r_presc_cnt;
  logic                 w_tick;
  logic [NB_GPIO-1:0]   w_stable;
  logic [NB_GPIO-1:0]   w_rise;
  logic [NB_GPIO-1:0]   w_fall;
  logic [NB_GPIO-1:0]   w_status;

  // >= rather than == so a lowered period ticks at once.
  assign w_tick = (r_presc_cnt >= bus.presc_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc_cnt <= '0;
    end else if (w_tick) begin
      r_presc_cnt <= '0;
    end else begin
      r_presc_cnt <= CNT_WIDTH'(r_presc_cnt + 1'b1);
    end
  end

  for (genvar g = 0; g < NB_GPIO; g++) begin : g_pin
    gpio_dbnc_cell #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_WIDTH   (CNT_WIDTH)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .i_pad     (bus.gpio_pad_i[g]),
      .i_tick    (w_tick),
      .i_len     (bus.dbnc_len_i),
      .i_dbnc_en (bus.dbnc_en_i[g]),
      .i_mode    (edge_mode_e'(bus.edge_mode_i[2*g+:2])),
      .i_clr     (bus.status_clr_i[g]),
      .o_stable  (w_stable[g]),
      .o_rise    (w_rise[g]),
      .o_fall    (w_fall[g]),
      .o_status  (w_status[g])
    );
  end

  assign bus.gpio_in_o = w_stable;
  assign bus.rise_o    = w_rise;
  assign bus.fall_o    = w_fall;
  assign bus.status_o  = w_status;
  assign bus.irq_o     = |(w_status & bus.irq_en_i);

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Bench for gpio_in_conditioner: directed scenarios with literal
// expectations, then random pads/config against a behavioural model.
module tb_gpio_in_conditioner;
  import gpio_cond_pkg::*;

  localparam int NB   = 32;
  localparam int S    = 2;
  localparam int CW   = 16;
  localparam int RING = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpio_in_conditioner_if #(.NB_GPIO(NB), .CNT_WIDTH(CW)) bus();

  gpio_in_conditioner #(
    .NB_GPIO(NB), .SYNC_STAGES(S), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_pass = 0;
  int n_tot  = 0;
  int rise0_cnt = 0;

  task automatic chk(input string name, input logic [NB-1:0] act,
                     input logic [NB-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  name, act, exp, $time);
  endtask

  // Behavioural model: pad log indexed by edge number, prescaler as
  // "cycles since last tick", debounce as "ticks seen since the
  // mismatch began" using a running global tick total.
  logic [NB-1:0] m_log [RING];
  longint        m_cyc, m_tstart, m_ntick;
  longint        m_base [NB];
  logic [NB-1:0] m_bval, m_gpio, m_rise, m_fall, m_status;

  always @(posedge clk or posedge rst) begin : p_model
    logic [NB-1:0] sync_v, nxt, set_v, rv, fv;
    logic [1:0]    md;
    bit            tk;
    longint        tot, b;
    if (rst) begin
      m_cyc <= 0; m_tstart <= 0; m_ntick <= 0;
      m_bval <= '0; m_gpio <= '0; m_rise <= '0;
      m_fall <= '0; m_status <= '0;
      for (int i = 0; i < RING; i++) m_log[i] <= '0;
      for (int i = 0; i < NB; i++) m_base[i] <= 0;
    end else begin
      sync_v = (m_cyc >= S) ? m_log[int'((m_cyc - S + 1) % RING)] : '0;
      tk  = (m_cyc - m_tstart) >= longint'(bus.presc_i);
      tot = m_ntick + (tk ? 1 : 0);
      nxt = m_gpio;
      for (int i = 0; i < NB; i++) begin
        if (!bus.dbnc_en_i[i] || bus.dbnc_len_i == 0) begin
          nxt[i] = sync_v[i];
          m_bval[i] <= 1'b0;
        end else if (sync_v[i] == m_gpio[i]) begin
          m_bval[i] <= 1'b0;
        end else begin
          b = m_bval[i] ? m_base[i] : m_ntick;
          if (tot - b == longint'(bus.dbnc_len_i)) begin
            nxt[i] = sync_v[i];
            m_bval[i] <= 1'b0;
          end else begin
            m_base[i] <= b;
            m_bval[i] <= 1'b1;
          end
        end
      end
      rv = nxt & ~m_gpio;
      fv = ~nxt & m_gpio;
      for (int i = 0; i < NB; i++) begin
        md = bus.edge_mode_i[2*i+:2];
        set_v[i] = (rv[i] & md[0]) | (fv[i] & md[1]);
      end
      m_status <= (m_status & ~bus.status_clr_i) | set_v;
      m_gpio <= nxt;
      m_rise <= rv;
      m_fall <= fv;
      m_log[int'((m_cyc + 1) % RING)] <= bus.gpio_pad_i;
      m_cyc <= m_cyc + 1;
      if (tk) m_tstart <= m_cyc + 1;
      m_ntick <= tot;
    end
  end

  always @(negedge clk) begin
    chk("gpio_in", bus.gpio_in_o, m_gpio);
    chk("rise", bus.rise_o, m_rise);
    chk("fall", bus.fall_o, m_fall);
    chk("status", bus.status_o, m_status);
    chk("irq", NB'(bus.irq_o), NB'(|(m_status & bus.irq_en_i)));
    if (bus.rise_o[0]) rise0_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int k;
    rst = 1'b1;
    bus.gpio_pad_i   = '1;
    bus.presc_i      = '0;
    bus.dbnc_len_i   = '0;
    bus.dbnc_en_i    = '0;
    bus.edge_mode_i  = {NB{2'b01}};
    bus.irq_en_i     = '0;
    bus.status_clr_i = '0;
    cyc(2);
    chk("rst_gpio", bus.gpio_in_o, '0);
    chk("rst_status", bus.status_o, '0);

    // Pads high out of reset, bypass on every pin
    rst = 1'b0;
    cyc(2);
    chk("t1_gpio_c2", bus.gpio_in_o, '0);
    cyc(1);
    chk("t1_gpio_c3", bus.gpio_in_o, 32'hFFFF_FFFF);
    chk("t1_rise_c3", bus.rise_o, 32'hFFFF_FFFF);
    chk("t1_fall_c3", bus.fall_o, '0);
    chk("t1_status_c3", bus.status_o, 32'hFFFF_FFFF);
    chk("t1_model_c3", m_gpio, 32'hFFFF_FFFF);
    cyc(1);
    chk("t1_rise_c4", bus.rise_o, '0);

    // Debounce glitch rejection and acceptance on pin 0
    bus.gpio_pad_i = '0;
    cyc(5);
    bus.status_clr_i = '1;
    cyc(1);
    bus.status_clr_i = '0;
    chk("t2_clr_all", bus.status_o, '0);
    bus.dbnc_en_i  = '1;
    bus.presc_i    = 3;
    bus.dbnc_len_i = 4;
    cyc(2);
    rise0_cnt = 0;
    bus.gpio_pad_i[0] = 1'b1;
    cyc(12);
    bus.gpio_pad_i[0] = 1'b0;
    cyc(30);
    chk("t2_glitch_gpio0", NB'(bus.gpio_in_o[0]), '0);
    chk("t2_glitch_rises", NB'(rise0_cnt), '0);
    bus.gpio_pad_i[0] = 1'b1;
    cyc(20);
    chk("t2_hold_gpio0", NB'(bus.gpio_in_o[0]), 1);
    chk("t2_model_hold", NB'(m_gpio[0]), 1);
    bus.gpio_pad_i[0] = 1'b0;
    cyc(30);
    chk("t2_hold_rises", NB'(rise0_cnt), 1);
    chk("t2_gpio0_back", NB'(bus.gpio_in_o[0]), '0);

    // Pin 5 fall-only status and interrupt, bypass
    bus.dbnc_en_i = '0;
    bus.edge_mode_i = '0;
    bus.edge_mode_i[11:10] = 2'b10;
    bus.irq_en_i = 32'h20;
    bus.status_clr_i = '1;
    cyc(1);
    bus.status_clr_i = '0;
    bus.gpio_pad_i[5] = 1'b1;
    cyc(5);
    chk("t3_status_rise", bus.status_o, '0);
    chk("t3_irq_rise", NB'(bus.irq_o), '0);
    bus.gpio_pad_i[5] = 1'b0;
    cyc(5);
    chk("t3_status_fall", bus.status_o, 32'h20);
    chk("t3_irq_fall", NB'(bus.irq_o), 1);
    bus.status_clr_i = 32'h20;
    cyc(1);
    bus.status_clr_i = '0;
    chk("t3_status_clr", bus.status_o, '0);
    chk("t3_irq_clr", NB'(bus.irq_o), '0);

    // Clear coincident with a new fall: set wins
    bus.gpio_pad_i[5] = 1'b1;
    cyc(5);
    bus.gpio_pad_i[5] = 1'b0;
    cyc(5);
    bus.gpio_pad_i[5] = 1'b1;
    cyc(5);
    chk("t4_status_pre", bus.status_o, 32'h20);
    bus.gpio_pad_i[5] = 1'b0;
    cyc(2);
    bus.status_clr_i = 32'h20;
    cyc(1);
    bus.status_clr_i = '0;
    chk("t4_fall_same", bus.fall_o, 32'h20);
    chk("t4_status_kept", bus.status_o, 32'h20);

    // Reset mid-debounce with 3 of 4 ticks counted on pin 0
    chk("t6_irq_pre", NB'(bus.irq_o), 1);
    bus.dbnc_en_i[0] = 1'b1;
    bus.presc_i = 3;
    bus.dbnc_len_i = 4;
    bus.gpio_pad_i[0] = 1'b1;
    k = 0;
    while (k < 100 && !(m_bval[0] && (m_ntick - m_base[0] == 3))) begin
      cyc(1);
      k++;
    end
    chk("t6_reach_cnt3", NB'(k < 100), 1);
    chk("t6_gpio0_pre", NB'(bus.gpio_in_o[0]), '0);
    rst = 1'b1;
    #1;
    chk("t6_rst_gpio", bus.gpio_in_o, '0);
    chk("t6_rst_status", bus.status_o, '0);
    chk("t6_rst_edges", bus.rise_o | bus.fall_o, '0);
    chk("t6_rst_irq", NB'(bus.irq_o), '0);
    cyc(2);
    rst = 1'b0;
    cyc(15);
    chk("t6_gpio0_c15", NB'(bus.gpio_in_o[0]), '0);
    cyc(1);
    chk("t6_gpio0_c16", NB'(bus.gpio_in_o[0]), 1);
    chk("t6_rise0_c16", NB'(bus.rise_o[0]), 1);

    // Prescaler period lowered from 100 to 2 at count 50
    bus.gpio_pad_i = 32'h2;
    bus.dbnc_en_i  = '1;
    bus.dbnc_len_i = 1;
    bus.presc_i    = 100;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(50);
    chk("t5_gpio1_c50", NB'(bus.gpio_in_o[1]), '0);
    bus.presc_i = 2;
    cyc(1);
    chk("t5_gpio1_c51", NB'(bus.gpio_in_o[1]), 1);
    chk("t5_rise1_c51", NB'(bus.rise_o[1]), 1);
    bus.gpio_pad_i = '0;
    cyc(2);
    chk("t5_gpio1_c53", NB'(bus.gpio_in_o[1]), 1);
    cyc(1);
    chk("t5_gpio1_c54", NB'(bus.gpio_in_o[1]), '0);
    chk("t5_fall1_c54", NB'(bus.fall_o[1]), 1);

    // Random pads with glitches; period/length change only when settled
    for (int ph = 0; ph < 8; ph++) begin
      bus.presc_i    = CW'($urandom_range(0, 3));
      bus.dbnc_len_i = CW'($urandom_range(0, 3));
      for (int c = 0; c < 150; c++) begin
        bus.gpio_pad_i ^= $urandom & $urandom & $urandom;
        if (c % 40 == 0) begin
          bus.dbnc_en_i   = $urandom;
          bus.edge_mode_i = {$urandom, $urandom};
        end
        if (c % 16 == 0) bus.irq_en_i = $urandom;
        bus.status_clr_i = (c % 8 == 3) ? ($urandom & $urandom) : '0;
        cyc(1);
      end
      bus.status_clr_i = '0;
      cyc(30);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
